// File: rtl/pcm_sample_recorder.sv
// pcm_sample_recorder: stores 18-bit capture words in an internal sample RAM and replays
// them as a valid-strobed PCM stream at one sample every DIV clocks.
// Optional feature: define PCM_REC_PEAK_EN to add the 'peak' output (max |sample| of the
// current recording, two's complement, most negative value saturated).
module pcm_sample_recorder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DIV    = 3125,
    parameter int unsigned SMP_W  = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SMP_W-1:0]  mic_data,
    input  logic              mic_done,
    input  logic              start_rec,
    input  logic              start_play,
    input  logic              stop,
    output logic [SMP_W-1:0]  pcm_out,
    output logic              pcm_valid,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   rec_len,
`ifdef PCM_REC_PEAK_EN
    output logic [SMP_W-1:0]  peak,
`endif
    output logic              play_done
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned TICK_W = $clog2(DIV);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StRec, StPlay} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]     rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]     rec_len_q, rec_len_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                full_q, full_d;
    logic                rd_pend_q, rd_pend_d;
    logic [SMP_W-1:0]    pcm_out_q, pcm_out_d;
    logic                pcm_valid_q, pcm_valid_d;
    logic                play_done_q, play_done_d;
    logic                busy_q, busy_d;
    logic                sync1_q, sync2_q, sync3_q, new_smp_q;
    logic                wr_en, rd_issue;
    logic [SMP_W-1:0]    rd_data_q;
    logic [SMP_W-1:0]    mem [DEPTH];

`ifdef PCM_REC_PEAK_EN
    logic [SMP_W-1:0]    peak_q, peak_d;
    logic [SMP_W-1:0]    mag;

    // Magnitude of the incoming word; the most negative code saturates to the max positive.
    always_comb begin
        mag = mic_data;
        if (mic_data[SMP_W-1]) begin
            if (mic_data[SMP_W-2:0] == '0) begin
                mag = {1'b0, {(SMP_W-1){1'b1}}};
            end else begin
                mag = ~mic_data + 1'b1;
            end
        end
    end
`endif

    // mic_done synchroniser and rising-edge pulse, registered so new_smp lands 3 clk after the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            new_smp_q <= 1'b0;
        end else begin
            sync1_q   <= mic_done;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            new_smp_q <= sync2_q & ~sync3_q;
        end
    end

    // Next-state and datapath control for the IDLE/REC/PLAY controller.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        rec_len_d   = rec_len_q;
        tick_d      = tick_q;
        full_d      = full_q;
        rd_pend_d   = rd_pend_q;
        pcm_out_d   = pcm_out_q;
        pcm_valid_d = 1'b0;
        play_done_d = 1'b0;
        wr_en       = 1'b0;
        rd_issue    = 1'b0;
`ifdef PCM_REC_PEAK_EN
        peak_d      = peak_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_rec) begin
                    state_d   = StRec;
                    wr_addr_d = '0;
                    rec_len_d = '0;
                    full_d    = 1'b0;
`ifdef PCM_REC_PEAK_EN
                    peak_d    = '0;
`endif
                end else if (start_play) begin
                    state_d   = StPlay;
                    rd_addr_d = '0;
                    tick_d    = '0;
                    rd_pend_d = 1'b0;
                end
            end
            StRec: begin
                // A sample arriving together with stop is still written.
                if (new_smp_q) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    rec_len_d = rec_len_q + 1'b1;
`ifdef PCM_REC_PEAK_EN
                    if (mag > peak_q) begin
                        peak_d = mag;
                    end
`endif
                    if (wr_addr_q == '1) begin
                        full_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                if (stop) begin
                    state_d = StIdle;
                end
            end
            StPlay: begin
                if (stop) begin
                    // Any read in flight is dropped without a strobe.
                    state_d   = StIdle;
                    rd_pend_d = 1'b0;
                end else if (rd_addr_q == rec_len_q) begin
                    // Also covers an empty recording: done one cycle after entry.
                    state_d     = StIdle;
                    play_done_d = 1'b1;
                end else begin
                    if (rd_pend_q) begin
                        pcm_out_d   = rd_data_q;
                        pcm_valid_d = 1'b1;
                        rd_addr_d   = rd_addr_q + 1'b1;
                        rd_pend_d   = 1'b0;
                    end
                    if (tick_q == TICK_MAX) begin
                        tick_d    = '0;
                        rd_issue  = 1'b1;
                        rd_pend_d = 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // Controller and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rec_len_q   <= '0;
            tick_q      <= '0;
            full_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            pcm_out_q   <= '0;
            pcm_valid_q <= 1'b0;
            play_done_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PCM_REC_PEAK_EN
            peak_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            rec_len_q   <= rec_len_d;
            tick_q      <= tick_d;
            full_q      <= full_d;
            rd_pend_q   <= rd_pend_d;
            pcm_out_q   <= pcm_out_d;
            pcm_valid_q <= pcm_valid_d;
            play_done_q <= play_done_d;
            busy_q      <= busy_d;
`ifdef PCM_REC_PEAK_EN
            peak_q      <= peak_d;
`endif
        end
    end

    // Sample RAM: synchronous write, one-cycle synchronous read; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= mic_data;
        end
        if (rd_issue) begin
            rd_data_q <= mem[rd_addr_q[ADDR_W-1:0]];
        end
    end

    assign pcm_out   = pcm_out_q;
    assign pcm_valid = pcm_valid_q;
    assign busy      = busy_q;
    assign full      = full_q;
    assign rec_len   = rec_len_q;
    assign play_done = play_done_q;
`ifdef PCM_REC_PEAK_EN
    assign peak      = peak_q;
`endif

endmodule

// File: tb/tb_pcm_sample_recorder.sv
// Bench for pcm_sample_recorder (ADDR_W=3, DIV=4) against a queue-based reference model.
module tb_pcm_sample_recorder;

    localparam int ADDR_W = 3;
    localparam int DIV    = 4;
    localparam int SMP_W  = 18;
    localparam int DEPTH  = 8;

    typedef logic [SMP_W-1:0] smp_q_t[$];

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [SMP_W-1:0]  mic_data = '0;
    logic              mic_done = 1'b0;
    logic              start_rec = 1'b0;
    logic              start_play = 1'b0;
    logic              stop = 1'b0;
    logic [SMP_W-1:0]  pcm_out;
    logic              pcm_valid;
    logic              busy;
    logic              full;
    logic [ADDR_W:0]   rec_len;
    logic              play_done;
`ifdef PCM_REC_PEAK_EN
    logic [SMP_W-1:0]  peak;
`endif

    int compared = 0;
    int mismatched = 0;

    logic [SMP_W-1:0]  model_q[$];
    logic [SMP_W-1:0]  model_peak;

    pcm_sample_recorder #(.ADDR_W(ADDR_W), .DIV(DIV), .SMP_W(SMP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mic_data   (mic_data),
        .mic_done   (mic_done),
        .start_rec  (start_rec),
        .start_play (start_play),
        .stop       (stop),
        .pcm_out    (pcm_out),
        .pcm_valid  (pcm_valid),
        .busy       (busy),
        .full       (full),
        .rec_len    (rec_len),
`ifdef PCM_REC_PEAK_EN
        .peak       (peak),
`endif
        .play_done  (play_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Absolute value of a two's-complement sample, clipped to the largest positive code.
    function automatic logic [SMP_W-1:0] mag_of(input logic [SMP_W-1:0] v);
        int s;
        s = v[SMP_W-1] ? int'(v) - (1 << SMP_W) : int'(v);
        if (s < 0) s = -s;
        if (s > (1 << (SMP_W - 1)) - 1) s = (1 << (SMP_W - 1)) - 1;
        return SMP_W'(s);
    endfunction

    task automatic pulse_start_rec();
        @(negedge clk) start_rec = 1'b1;
        @(negedge clk) start_rec = 1'b0;
    endtask

    task automatic pulse_start_play();
        @(negedge clk) start_play = 1'b1;
        @(negedge clk) start_play = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    // One capture word: data set up before the done level rises.
    task automatic send_sample(input logic [SMP_W-1:0] d);
        @(negedge clk);
        mic_data = d;
        mic_done = 1'b1;
        repeat (5) @(negedge clk);
        mic_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic model_push(input logic [SMP_W-1:0] d);
        if (model_q.size() < DEPTH) begin
            model_q.push_back(d);
            if (mag_of(d) > model_peak) model_peak = mag_of(d);
        end
    endtask

    task automatic check_rec_state(input string tag);
        check({tag, "_rec_len"}, 32'(rec_len), 32'(model_q.size()));
        check({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
        check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef PCM_REC_PEAK_EN
        check({tag, "_peak"}, 32'(peak), 32'(model_peak));
`endif
    endtask

    task automatic do_record(input string tag, input smp_q_t data);
        pulse_start_rec();
        model_q.delete();
        model_peak = '0;
        foreach (data[i]) begin
            send_sample(data[i]);
            model_push(data[i]);
        end
        pulse_stop();
        @(negedge clk);
        check_rec_state(tag);
    endtask

    // Replays and checks every strobe value and its cycle offset from start_play.
    task automatic do_play(input string tag);
        int k, nstr, ndone, done_k, n, bound, exp_done;
        n = model_q.size();
        bound = DIV * (DEPTH + 2) + 10;
        k = 0; nstr = 0; ndone = 0; done_k = -1;
        @(negedge clk) start_play = 1'b1;
        @(negedge clk) start_play = 1'b0;
        while (done_k < 0 && k < bound) begin
            @(negedge clk);
            k++;
            if (pcm_valid === 1'b1) begin
                if (nstr < n) begin
                    check({tag, "_value"}, 32'(pcm_out), 32'(model_q[nstr]));
                    check({tag, "_strobe_time"}, 32'(k), 32'(DIV + 1 + DIV * nstr));
                end
                nstr++;
            end
            if (play_done === 1'b1) begin
                ndone++;
                done_k = k;
            end
        end
        exp_done = (n == 0) ? 1 : DIV + 1 + DIV * (n - 1) + 1;
        check({tag, "_done_time"}, 32'(done_k), 32'(exp_done));
        repeat (2 * DIV) begin
            @(negedge clk);
            if (pcm_valid === 1'b1) nstr++;
            if (play_done === 1'b1) ndone++;
        end
        check({tag, "_strobes"}, 32'(nstr), 32'(n));
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        if (n > 0) check({tag, "_hold"}, 32'(pcm_out), 32'(model_q[n - 1]));
    endtask

    initial begin
        smp_q_t data;
        logic [31:0] r;
        int nstr, k;

        // Reset state
        reset = 1'b0;
        #1;
        check("rst_pcm_out", 32'(pcm_out), 32'd0);
        check("rst_pcm_valid", 32'(pcm_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rec_len", 32'(rec_len), 32'd0);
        check("rst_play_done", 32'(play_done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Five samples then stop
        data.delete();
        for (int i = 1; i <= 5; i++) data.push_back(SMP_W'(i));
        do_record("rec5", data);
        do_play("play5");

        // Overfill: only the first DEPTH are kept
        data.delete();
        for (int i = 0; i < 10; i++) data.push_back(SMP_W'('h3FFF0 + i));
        do_record("rec10", data);
        do_play("play10");

        // Capture words in IDLE are ignored
        send_sample(SMP_W'('h0ABCD));
        @(negedge clk);
        check("idle_smp_rec_len", 32'(rec_len), 32'(DEPTH));

        // stop mid-playback: no further strobes, no play_done
        pulse_start_play();
        repeat (7) @(negedge clk);
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        nstr = 0; k = 0;
        repeat (3 * DIV) begin
            @(negedge clk);
            if (pcm_valid === 1'b1) nstr++;
            if (play_done === 1'b1) k++;
        end
        check("stop_play_strobes", 32'(nstr), 32'd0);
        check("stop_play_done", 32'(k), 32'd0);
        check("stop_play_busy", 32'(busy), 32'd0);
        check("stop_play_hold", 32'(pcm_out), 32'(model_q[0]));

        // start_rec wins over simultaneous start_play; start_play in REC ignored
        @(negedge clk) begin start_rec = 1'b1; start_play = 1'b1; end
        @(negedge clk) begin start_rec = 1'b0; start_play = 1'b0; end
        pulse_start_play();
        send_sample(SMP_W'('h00123));
        @(negedge clk);
        check("simul_busy", 32'(busy), 32'd1);
        check("simul_rec_len", 32'(rec_len), 32'd1);
        model_q.delete();
        model_peak = '0;
        model_push(SMP_W'('h00123));
        pulse_stop();
        @(negedge clk);
        check_rec_state("simul");
        do_play("simul_play");

        // Empty recording: immediate play_done, no strobe
        data.delete();
        do_record("rec0", data);
        do_play("play0");

`ifdef PCM_REC_PEAK_EN
        data.delete();
        data.push_back(SMP_W'('h00010));
        data.push_back(SMP_W'('h3FF00));
        data.push_back(SMP_W'('h20000));
        do_record("peak_rec", data);
        check("peak_sat", 32'(peak), 32'h1FFFF);
`endif

        // Randomized recordings
        for (int it = 0; it < 5; it++) begin
            data.delete();
            r = $urandom_range(0, 10);
            for (int i = 0; i < int'(r); i++) begin
                logic [31:0] w;
                w = $urandom;
                data.push_back(w[SMP_W-1:0]);
            end
            do_record("rnd_rec", data);
            do_play("rnd_play");
        end

        // Reset in the middle of playback
        data.delete();
        for (int i = 0; i < DEPTH; i++) data.push_back(SMP_W'(i * 3 + 7));
        do_record("pre_rst_rec", data);
        pulse_start_play();
        nstr = 0; k = 0;
        while (nstr < 2 && k < 60) begin
            @(negedge clk);
            k++;
            if (pcm_valid === 1'b1) nstr++;
        end
        check("pre_rst_strobes", 32'(nstr), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pcm_out", 32'(pcm_out), 32'd0);
        check("mid_rst_pcm_valid", 32'(pcm_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_rec_len", 32'(rec_len), 32'd0);
        check("mid_rst_play_done", 32'(play_done), 32'd0);
`ifdef PCM_REC_PEAK_EN
        check("mid_rst_peak", 32'(peak), 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_q.delete();
        do_play("post_rst_play");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pcm_sample_recorder.md
Name: pcm_sample_recorder

Overview:
- Stage directly downstream of the microphone capture block.
- Takes each completed 18-bit serial-audio word (sdata, qualified by the capture block's done level) and stores it in an internal sample RAM.
- On command, replays the stored samples at a fixed output rate as a valid-strobed 18-bit PCM stream for the PWM/DAC playback stage.
- Provides the record/playback buffering for the audio path of the game board.

Parameters:
ADDR_W, 10, sample RAM address width; depth DEPTH = 2**ADDR_W samples.
DIV, 3125, playback tick period in clk cycles (50 MHz / 16 kHz); must be >= 3.
SMP_W, 18, sample width; matches capture output.

Ports:
clk  input  1  system clock, single domain.
reset  input  1  asynchronous, active-low reset (0 = reset).
mic_data  input  SMP_W  sample word from capture block (sdata).
mic_done  input  1  capture done level; asynchronous to clk, synchronised here.
start_rec  input  1  one-cycle pulse: begin recording at address 0.
start_play  input  1  one-cycle pulse: begin playback from address 0.
stop  input  1  one-cycle pulse: end current record/playback.
pcm_out  output  SMP_W  playback sample.
pcm_valid  output  1  one-cycle strobe, pcm_out valid.
busy  output  1  high in REC or PLAY.
full  output  1  high when last record filled all DEPTH entries.
rec_len  output  ADDR_W+1  number of samples held (0..DEPTH).
play_done  output  1  one-cycle pulse at playback end.

Behaviour:
- Reset (reset=0, async): state IDLE; pcm_out=0, pcm_valid=0, busy=0, full=0, rec_len=0, play_done=0; address and tick counters 0; sync flops 0. RAM contents are not cleared. Reset mid-operation aborts immediately.
- mic_done passes through a 2-FF synchroniser. A rising edge of the synchronised level generates new_smp, a one-cycle pulse 3 clk after the raw edge. mic_data is sampled on new_smp; it is stable at that point because the capture block updates sdata before asserting done.
- FSM states: IDLE, REC, PLAY.
- IDLE:
  - start_rec -> REC: wr_addr=0, rec_len=0, full=0.
  - Otherwise start_play -> PLAY: rd_addr=0, tick counter=0.
  - start_rec and start_play in the same cycle: start_rec wins.
  - stop is ignored.
  - new_smp is ignored.
- REC:
  - Each new_smp writes mem[wr_addr]=mic_data, then wr_addr++ and rec_len++.
  - After the write to address DEPTH-1: full=1, rec_len=DEPTH, -> IDLE. No wrap-around; later samples are discarded.
  - stop -> IDLE; rec_len keeps the count written so far.
  - stop and new_smp in the same cycle: the sample is written first, then -> IDLE.
  - start_rec and start_play are ignored.
- PLAY:
  - rec_len==0 on entry: play_done pulses in the next cycle, -> IDLE, pcm_valid never asserts.
  - Tick counter counts 0..DIV-1. At count DIV-1, issue a RAM read of rd_addr (synchronous RAM, 1-cycle latency).
  - The following cycle: pcm_out=mem[rd_addr], pcm_valid=1 for one cycle, rd_addr++.
  - When rd_addr reaches rec_len after an output: play_done=1 for one cycle, -> IDLE. Total strobes = rec_len, spaced exactly DIV cycles apart; first strobe DIV+1 cycles after start_play.
  - stop -> IDLE with no play_done. A read already issued is dropped; no strobe.
  - start_rec and start_play are ignored.
- pcm_out holds the last value between strobes and after playback.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro PCM_REC_PEAK_EN.
- Defined:
  - Adds output peak [SMP_W-1:0]: maximum |sample| of the current recording, samples treated as two's complement.
  - Cleared on start_rec and updated on every write.
  - |−2^(SMP_W-1)| saturates to 2^(SMP_W-1)−1.
  - Reset value 0.
- Undefined: no peak port and no peak logic.

Test Plan:
- Config ADDR_W=3, DIV=4. Reset, start_rec, 5 mic_done rising edges with data 0x00001..0x00005, then stop -> rec_len=5, full=0, busy returns 0.
- start_play after the above -> exactly 5 pcm_valid strobes, 4 clk apart, values 1..5. play_done pulses once, one cycle after the 5th strobe.
- Record 10 edges (data 0x3FFF0+i) -> writes stop after 8; full=1, rec_len=8; playback yields 0x3FFF0..0x3FFF7.
- Simultaneous start_rec+start_play in IDLE -> REC entered; start_play during REC has no effect. Then rec_len=0 followed by start_play -> play_done next cycle, no pcm_valid.
- Assert reset=0 mid-PLAY after 2 strobes -> all outputs 0 asynchronously, state IDLE. A following start_play with rec_len=0 gives immediate play_done.
- PCM_REC_PEAK_EN: record 0x00010, 0x3FF00 (−256), 0x20000 -> peak = 0x1FFFF.
